// File: rtl/status_led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : status_led_sequencer
//  Purpose  : Drives the board status LED from a slow prescaler tap. Modes:
//             off, steady on, blink, and a repeating error-code flash
//             (N pulses followed by a dark pause).
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1  system clock, all state updates on posedge
//    reset      in   1  asynchronous, active-high
//    tick       in   1  prescaler tap (square wave), synchronous to clk
//    mode       in   2  00 off, 01 steady on, 10 blink, 11 error code
//    error_code in   4  pulse count for mode 11 (0 = pause only)
//    led        out  1  LED drive, active-high, registered
//    frame_done out  1  one-clk pulse at end of each error-code frame
//    frame_cnt  out  8  completed-frame counter (STATUS_LED_FRAME_CNT_EN only)
//  Configuration macro: STATUS_LED_FRAME_CNT_EN
// ============================================================================
module status_led_sequencer #(
    parameter int ON_TICKS    = 2,
    parameter int OFF_TICKS   = 2,
    parameter int PAUSE_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [1:0] mode,
    input  logic [3:0] error_code,
    output logic       led,
    output logic       frame_done
`ifdef STATUS_LED_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam logic [1:0] c_MODE_OFF   = 2'b00;
    localparam logic [1:0] c_MODE_ON    = 2'b01;
    localparam logic [1:0] c_MODE_BLINK = 2'b10;
    localparam logic [1:0] c_MODE_CODE  = 2'b11;

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_PULSE_ON  = 2'd1;
    localparam logic [1:0] c_PULSE_OFF = 2'd2;
    localparam logic [1:0] c_PAUSE     = 2'd3;

    localparam logic [3:0] c_ON_LEN    = 4'(ON_TICKS);
    localparam logic [3:0] c_OFF_LEN   = 4'(OFF_TICKS);
    localparam logic [3:0] c_PAUSE_LEN = 4'(PAUSE_TICKS);

    logic       r_tick_q;
    logic [1:0] r_mode_q;
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] r_dur_cnt;
    logic [3:0] r_code_q;
    logic [3:0] r_pulses_done;
    logic       r_led;
    logic       r_frame_done;
    logic       w_led_nxt;
    logic       w_frame_done_nxt;
    logic       w_tick_rise;
    logic       w_mode_chg;
    logic       w_run;
    logic       w_fire;

    assign w_tick_rise = tick & ~r_tick_q;
    assign w_mode_chg  = (mode != r_mode_q);

    // A tick rise that the error-code sequencer is allowed to consume; a
    // simultaneous mode change swallows it.
    assign w_run  = (mode == c_MODE_CODE) && !w_mode_chg && w_tick_rise;
    // IDLE leaves on the first rise; timed states leave when the duration
    // counter, loaded on entry, is on its last count.
    assign w_fire = w_run && ((r_state == c_IDLE) || (r_dur_cnt == 4'd1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (w_mode_chg || (r_mode_q != c_MODE_CODE)) begin
            w_state_nxt = c_IDLE;
        end else if (w_fire) begin
            case (r_state)
                c_IDLE, c_PAUSE: w_state_nxt = (error_code != 4'd0) ? c_PULSE_ON : c_PAUSE;
                c_PULSE_ON:      w_state_nxt = c_PULSE_OFF;
                c_PULSE_OFF:     w_state_nxt = (r_pulses_done != r_code_q) ? c_PULSE_ON : c_PAUSE;
                default:         w_state_nxt = c_IDLE;
            endcase
        end
    end

    // Output logic (values registered in the datapath process)
    always_comb begin
        w_led_nxt        = r_led;
        w_frame_done_nxt = 1'b0;
        if (w_mode_chg) begin
            w_led_nxt = (mode == c_MODE_ON);
        end else begin
            case (r_mode_q)
                c_MODE_OFF:   w_led_nxt = 1'b0;
                c_MODE_ON:    w_led_nxt = 1'b1;
                c_MODE_BLINK: w_led_nxt = w_tick_rise ? ~r_led : r_led;
                default: begin
                    w_led_nxt        = (w_state_nxt == c_PULSE_ON);
                    w_frame_done_nxt = w_fire && (r_state == c_PAUSE);
                end
            endcase
        end
    end

    // Datapath: edge detector, mode tracking, counters, registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_q      <= 1'b1;   // a tick already high at release is not an edge
            r_mode_q      <= c_MODE_OFF;
            r_dur_cnt     <= 4'd0;
            r_code_q      <= 4'd0;
            r_pulses_done <= 4'd0;
            r_led         <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_tick_q     <= tick;
            r_led        <= w_led_nxt;
            r_frame_done <= w_frame_done_nxt;
            if (w_mode_chg) begin
                r_mode_q      <= mode;
                r_dur_cnt     <= 4'd0;
                r_code_q      <= 4'd0;
                r_pulses_done <= 4'd0;
            end else if (w_fire) begin
                case (w_state_nxt)
                    c_PULSE_ON:  r_dur_cnt <= c_ON_LEN;
                    c_PULSE_OFF: r_dur_cnt <= c_OFF_LEN;
                    c_PAUSE:     r_dur_cnt <= c_PAUSE_LEN;
                    default:     r_dur_cnt <= 4'd0;
                endcase
                // Frame start: latch the code and restart the pulse tally.
                if ((r_state == c_IDLE) || (r_state == c_PAUSE)) begin
                    r_code_q      <= error_code;
                    r_pulses_done <= 4'd0;
                end else if (r_state == c_PULSE_ON) begin
                    r_pulses_done <= r_pulses_done + 4'd1;
                end
            end else if (w_run) begin
                r_dur_cnt <= r_dur_cnt - 4'd1;
            end
        end
    end

`ifdef STATUS_LED_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= 8'd0;
        end else if (w_mode_chg) begin
            r_frame_cnt <= 8'd0;
        end else if (w_frame_done_nxt) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;   // wraps 255 -> 0
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign led        = r_led;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_status_led_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_status_led_sequencer
//  Purpose  : Self-checking bench for status_led_sequencer. A frame-position
//             reference model predicts led / frame_done every clock.
//  Revision : 1.0  initial release
// ============================================================================
module tb_status_led_sequencer;

    localparam int c_ON    = 2;
    localparam int c_OFF   = 2;
    localparam int c_PAUSE = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [1:0] mode;
    logic [3:0] error_code;
    logic       led;
    logic       frame_done;
`ifdef STATUS_LED_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    status_led_sequencer #(
        .ON_TICKS    (c_ON),
        .OFF_TICKS   (c_OFF),
        .PAUSE_TICKS (c_PAUSE)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .mode       (mode),
        .error_code (error_code),
        .led        (led),
        .frame_done (frame_done)
`ifdef STATUS_LED_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int ph          = 0;
    int fd_seen     = 0;

    // Reference model: position (in tick rises) within the current frame.
    logic       m_tick_q;
    logic [1:0] m_mode_q;
    logic       m_led;
    logic       m_fd;
    int         m_pos;
    int         m_code;
    int         m_fcnt;

    task automatic model_reset();
        m_tick_q = 1'b1;
        m_mode_q = 2'b00;
        m_led    = 1'b0;
        m_fd     = 1'b0;
        m_pos    = -1;
        m_code   = 0;
        m_fcnt   = 0;
    endtask

    task automatic model_step();
        logic rise;
        rise     = tick & ~m_tick_q;
        m_tick_q = tick;
        m_fd     = 1'b0;
        if (mode != m_mode_q) begin
            m_mode_q = mode;
            m_led    = (mode == 2'b01);
            m_pos    = -1;
            m_fcnt   = 0;
        end else if (mode == 2'b10) begin
            if (rise) m_led = ~m_led;
        end else if (mode == 2'b11 && rise) begin
            if (m_pos < 0) begin
                m_pos  = 0;
                m_code = int'(error_code);
            end else begin
                m_pos++;
                if (m_pos == m_code * (c_ON + c_OFF) + c_PAUSE) begin
                    m_fd   = 1'b1;
                    m_fcnt = (m_fcnt + 1) % 256;
                    m_pos  = 0;
                    m_code = int'(error_code);
                end
            end
            m_led = (m_pos < m_code * (c_ON + c_OFF)) && ((m_pos % (c_ON + c_OFF)) < c_ON);
        end
    endtask

    task automatic check(input string tag);
        vectors++;
        assert (led === m_led) else begin
            miscompares++;
            $error("FAIL %s led observed=%0b expected=%0b", tag, led, m_led);
        end
        assert (frame_done === m_fd) else begin
            miscompares++;
            $error("FAIL %s frame_done observed=%0b expected=%0b", tag, frame_done, m_fd);
        end
`ifdef STATUS_LED_FRAME_CNT_EN
        assert (frame_cnt === 8'(m_fcnt)) else begin
            miscompares++;
            $error("FAIL %s frame_cnt observed=%0d expected=%0d", tag, frame_cnt, m_fcnt);
        end
`endif
    endtask

    task automatic cyc(input logic t, input logic [1:0] md, input logic [3:0] ec, input string tag);
        @(negedge clk);
        tick       = t;
        mode       = md;
        error_code = ec;
        model_step();
        @(posedge clk);
        #1;
        if (frame_done === 1'b1) fd_seen++;
        check(tag);
    endtask

    // Square-wave tick: low for the first half of each period, so rises land
    // at ph = k*per + per/2.
    task automatic run(input int n, input int per, input logic [1:0] md, input logic [3:0] ec,
                       input string tag);
        for (int i = 0; i < n; i++) begin
            cyc(((ph % per) >= per / 2), md, ec, tag);
            ph++;
        end
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check(tag);
        @(posedge clk);
        #1;
        check({tag, "_held"});
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        tick       = 1'b0;
        mode       = 2'b00;
        error_code = 4'd0;
        model_reset();
        #12;
        check("reset_values");
        @(negedge clk);
        reset = 1'b0;

        // Steady on takes effect on the first edge, off on the next.
        cyc(1'b0, 2'b01, 4'd0, "mode01_entry");
        cyc(1'b0, 2'b00, 4'd0, "mode00_entry");

        // Blink, tick period 8.
        ph = 0;
        run(64, 8, 2'b10, 4'd0, "blink");

        // Error code 3, two full frames and more.
        cyc(1'b0, 2'b00, 4'd0, "to_off");
        ph = 0;
        run(200, 4, 2'b11, 4'd3, "code3");

        // Error code 0: pause-only frames.
        cyc(1'b0, 2'b00, 4'd0, "to_off");
        ph = 0;
        run(100, 4, 2'b11, 4'd0, "code0");

        // Code 3 -> 5 at rise 6: frame_done expected only at rises 20 and 48.
        cyc(1'b0, 2'b00, 4'd0, "to_off");
        ph      = 0;
        fd_seen = 0;
        run(26, 4, 2'b11, 4'd3, "code_chg_a");
        run(200, 4, 2'b11, 4'd5, "code_chg_b");
        vectors++;
        assert (fd_seen === 2) else begin
            miscompares++;
            $error("FAIL code_chg_frames frame_done count observed=%0d expected=2", fd_seen);
        end

        // Mode change coincident with a tick rise: rise is ignored.
        cyc(1'b0, 2'b10, 4'd5, "pre_chg");
        cyc(1'b0, 2'b10, 4'd5, "pre_chg");
        cyc(1'b1, 2'b11, 4'd5, "chg_with_rise");
        cyc(1'b1, 2'b11, 4'd5, "chg_with_rise_hold");
        ph = 0;
        run(40, 4, 2'b11, 4'd2, "after_chg");

        // Reset during PULSE_ON.
        cyc(1'b0, 2'b00, 4'd0, "to_off");
        ph = 0;
        run(4, 4, 2'b11, 4'd3, "into_pulse_on");
        async_reset("reset_mid_pulse");
        ph = 0;
        run(40, 4, 2'b11, 4'd3, "after_reset");

        // Randomized segments.
        for (int s = 0; s < 30; s++) begin
            logic [1:0] md;
            logic [3:0] ec;
            int         per;
            int         len;
            md  = 2'($urandom_range(0, 3));
            ec  = 4'($urandom_range(0, 15));
            per = 2 * int'($urandom_range(1, 6));
            len = int'($urandom_range(20, 150));
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 40) == 0) ec = 4'($urandom_range(0, 15));
                cyc(((ph % per) >= per / 2), md, ec, "random");
                ph++;
            end
        end

`ifdef STATUS_LED_FRAME_CNT_EN
        // frame_cnt wrap: 258 pause-only frames of 16 clk each.
        cyc(1'b0, 2'b00, 4'd0, "to_off");
        ph = 0;
        run(16 * 258 + 4, 2, 2'b11, 4'd0, "frame_cnt_wrap");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
